// File: rtl/link_buffer.sv
// link_buffer: circular flit FIFO between a router tx port and a neighbour rx port, with occupancy and delivered-flit statistics
module link_buffer #(
  parameter int ID = -1,
  parameter int SIZE = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_req,
  output logic                  in_ack,
  input  logic [SIZE-1:0]       in_data,
  output logic                  out_req,
  input  logic                  out_ack,
  output logic [SIZE-1:0]       out_data,
  output logic [DEPTH_LOG2:0]   occupancy,
  output logic [15:0]           flit_count
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [SIZE-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  push, pop;

  assign in_ack    = count != FULL;
  assign out_req   = count != '0;
  assign out_data  = out_req ? mem[rd_ptr] : '0;
  assign occupancy = count;
  assign push      = in_req && in_ack;
  assign pop       = out_req && out_ack;

  always_ff @(posedge clk)
    if (push && !reset) mem[wr_ptr] <= in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      flit_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop) flit_count <= flit_count + 16'd1;
      count <= count + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
    end
  end
endmodule

// File: tb/tb_link_buffer.sv
// tb_link_buffer: scoreboard bench; a driver logs accepted flits, a monitor checks each delivered flit in order
module tb_link_buffer;
  logic       clk, reset, in_req, in_ack, out_req, out_ack, acc;
  logic [7:0] in_data, out_data;
  logic [2:0] occupancy;
  logic [15:0] flit_count;
  logic [7:0] tx_q [$];
  logic [7:0] exp_q [$];
  int vectors = 0, errors = 0;

  link_buffer #(.ID(3), .SIZE(8), .DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
    .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
    .occupancy(occupancy), .flit_count(flit_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (tx_q.size() == 0 && exp_q.size() == 0 && !out_req) break;
      step(1);
    end
    chk("drain_timeout", 32'(i < budget), 32'd1);
  endtask

  always @(negedge clk) acc <= in_req && in_ack && !reset;

  initial begin
    in_req = 0;
    in_data = 0;
    forever begin
      @(posedge clk);
      #2;
      if (acc) begin
        exp_q.push_back(in_data);
        void'(tx_q.pop_front());
      end
      in_req = tx_q.size() != 0;
      in_data = in_req ? tx_q[0] : 8'h00;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_req && out_ack) begin
        if (exp_q.size() == 0) chk("unexpected_flit", 32'(out_data), 32'hFFFF_FFFF);
        else chk("flit_order", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1;
    out_ack = 0;
    step(2);
    reset = 0;
    chk("rst_in_ack", 32'(in_ack), 1);
    chk("rst_out_req", 32'(out_req), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_fc", 32'(flit_count), 0);
    tx_q.push_back(8'hA5);
    step(1);
    chk("t1_out_req", 32'(out_req), 1);
    chk("t1_out_data", 32'(out_data), 32'hA5);
    chk("t1_occ", 32'(occupancy), 1);
    out_ack = 1;
    step(1);
    out_ack = 0;
    chk("t1_out_req_low", 32'(out_req), 0);
    chk("t1_fc", 32'(flit_count), 1);
    for (int i = 1; i <= 5; i++) tx_q.push_back(8'(i));
    step(4);
    chk("t2_in_ack_full", 32'(in_ack), 0);
    chk("t2_occ", 32'(occupancy), 4);
    chk("t2_head", 32'(out_data), 1);
    out_ack = 1;
    step(1);
    out_ack = 0;
    chk("t3_occ", 32'(occupancy), 3);
    chk("t3_in_ack", 32'(in_ack), 1);
    step(1);
    chk("t3_refill", 32'(occupancy), 4);
    out_ack = 1;
    wait_idle(50);
    chk("t2_fc", 32'(flit_count), 6);
    out_ack = 0;
    for (int i = 0; i < 22; i++) tx_q.push_back(8'(8'h10 + i));
    step(2);
    chk("t4_half", 32'(occupancy), 2);
    out_ack = 1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("t4_occ_const", 32'(occupancy), 2);
    end
    wait_idle(50);
    chk("t4_fc", 32'(flit_count), 28);
    out_ack = 0;
    tx_q.push_back(8'hAA);
    tx_q.push_back(8'hBB);
    tx_q.push_back(8'hCC);
    step(3);
    chk("t5_occ3", 32'(occupancy), 3);
    reset = 1;
    step(1);
    reset = 0;
    exp_q.delete();
    chk("t5_occ", 32'(occupancy), 0);
    chk("t5_out_req", 32'(out_req), 0);
    chk("t5_in_ack", 32'(in_ack), 1);
    chk("t5_fc", 32'(flit_count), 0);
    tx_q.push_back(8'h5A);
    out_ack = 1;
    wait_idle(50);
    chk("t5_fc_after", 32'(flit_count), 1);
    reset = 1;
    step(1);
    reset = 0;
    exp_q.delete();
    for (int i = 0; i < 65537; i++) tx_q.push_back(8'(i * 7));
    wait_idle(70000);
    chk("t6_fc_wrap", 32'(flit_count), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
